// File: rtl/rom_dl_router.sv
// rom_dl_router: routes the HPS ROM download stream onto the game core's ROM write port.
// Decodes the linear byte address into four one-hot regions, registers the write strobe,
// counts accepted bytes and only releases the core reset after a complete, in-range load
// followed by a hold-off period.
// Optional feature: define ROM_DL_CKSUM_EN to build the 16-bit additive checksum on CKSUM;
// without it CKSUM is tied to zero.
`timescale 1ns / 1ps

module rom_dl_router #(
    parameter logic [24:0] R0_END = 25'h0C000,
    parameter logic [24:0] R1_END = 25'h10000,
    parameter logic [24:0] R2_END = 25'h18000,
    parameter logic [24:0] R3_END = 25'h20000,
    parameter int unsigned HOLD   = 16
) (
    input  logic        MCLK,
    input  logic        RESET_N,
    input  logic        DL_ACTIVE,
    input  logic        DL_WR,
    input  logic [24:0] DL_ADDR,
    input  logic [7:0]  DL_DATA,
    output logic        ROM_WE,
    output logic [3:0]  ROM_CS,
    output logic [16:0] ROM_AD,
    output logic [7:0]  ROM_DT,
    output logic        CORE_RST_N,
    output logic        LOAD_OK,
    output logic [1:0]  LOAD_ERR,
    output logic [15:0] CKSUM
);

    typedef enum logic [2:0] {StIdle, StLoad, StCheck, StHold, StRun, StFail} state_e;

    state_e      state_q, state_d;
    logic [24:0] cnt_q, cnt_d;
    logic [15:0] hold_q, hold_d;
    logic        we_q, we_d;
    logic [3:0]  cs_q, cs_d;
    logic [16:0] ad_q, ad_d;
    logic [7:0]  dt_q, dt_d;
    logic        rst_n_q, rst_n_d;
    logic        ok_q, ok_d;
    logic [1:0]  err_q, err_d;
    logic        wr_acc;
    logic        load_clr;
    logic [24:0] base;

    // A write is only taken while loading and only below the end of the last region
    assign wr_acc = (state_q == StLoad) && DL_WR && (DL_ADDR < R3_END);

    // Next-state, write-path decode and status updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        we_d     = 1'b0;
        cs_d     = 4'b0000;
        ad_d     = ad_q;
        dt_d     = dt_q;
        ok_d     = ok_q;
        err_d    = err_q;
        load_clr = 1'b0;
        base     = '0;

        if (wr_acc) begin
            if (DL_ADDR < R0_END) begin
                cs_d = 4'b0001;
                base = '0;
            end else if (DL_ADDR < R1_END) begin
                cs_d = 4'b0010;
                base = R0_END;
            end else if (DL_ADDR < R2_END) begin
                cs_d = 4'b0100;
                base = R1_END;
            end else begin
                cs_d = 4'b1000;
                base = R2_END;
            end
            we_d = 1'b1;
            ad_d = 17'(DL_ADDR - base);
            dt_d = DL_DATA;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 25'd1;
            end
        end

        case (state_q)
            StIdle: begin
                if (DL_ACTIVE) begin
                    state_d  = StLoad;
                    load_clr = 1'b1;
                end
            end
            StLoad: begin
                if (DL_WR && !(DL_ADDR < R3_END)) begin
                    err_d[0] = 1'b1;
                end
                // A strobe coinciding with the fall of DL_ACTIVE is still counted above
                if (!DL_ACTIVE) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if ((cnt_q == R3_END) && !err_q[0]) begin
                    state_d = StHold;
                    hold_d  = 16'(HOLD - 1);
                end else begin
                    if (cnt_q < R3_END) begin
                        err_d[1] = 1'b1;
                    end
                    state_d = StFail;
                end
            end
            StHold: begin
                if (hold_q == 16'd0) begin
                    state_d = StRun;
                    ok_d    = 1'b1;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            StRun, StFail: begin
                if (DL_ACTIVE) begin
                    state_d  = StLoad;
                    load_clr = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load_clr) begin
            cnt_d = '0;
            err_d = 2'b00;
            ok_d  = 1'b0;
        end

        // Registered so the core reset drops in the same edge that leaves RUN
        rst_n_d = (state_d == StRun);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hold_q  <= '0;
            we_q    <= 1'b0;
            cs_q    <= 4'b0000;
            ad_q    <= '0;
            dt_q    <= '0;
            rst_n_q <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            we_q    <= we_d;
            cs_q    <= cs_d;
            ad_q    <= ad_d;
            dt_q    <= dt_d;
            rst_n_q <= rst_n_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

`ifdef ROM_DL_CKSUM_EN
    logic [15:0] cksum_q, cksum_d;

    // Running sum of accepted bytes, restarted on every LOAD entry
    always_comb begin
        cksum_d = cksum_q;
        if (load_clr) begin
            cksum_d = '0;
        end else if (wr_acc) begin
            cksum_d = cksum_q + {8'h00, DL_DATA};
        end
    end

    // Checksum register
    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign CKSUM = cksum_q;
`else
    assign CKSUM = 16'h0000;
`endif

    assign ROM_WE     = we_q;
    assign ROM_CS     = cs_q;
    assign ROM_AD     = ad_q;
    assign ROM_DT     = dt_q;
    assign CORE_RST_N = rst_n_q;
    assign LOAD_OK    = ok_q;
    assign LOAD_ERR   = err_q;

endmodule

// File: tb/tb_rom_dl_router.sv
// Bench for rom_dl_router: boundary-decode vector table, scoreboard on the ROM write port,
// and hand-written sequences for load completion, errors, reset and re-download.
// Region ends are scaled down by 128 to keep every full load short.
`timescale 1ns / 1ps

module tb_rom_dl_router;

    localparam logic [24:0] TB_R0   = 25'h00180;
    localparam logic [24:0] TB_R1   = 25'h00200;
    localparam logic [24:0] TB_R2   = 25'h00300;
    localparam logic [24:0] TB_R3   = 25'h00400;
    localparam int unsigned TB_HOLD = 16;
`ifdef ROM_DL_CKSUM_EN
    localparam bit CkEn = 1'b1;
`else
    localparam bit CkEn = 1'b0;
`endif

    logic        MCLK;
    logic        RESET_N;
    logic        DL_ACTIVE;
    logic        DL_WR;
    logic [24:0] DL_ADDR;
    logic [7:0]  DL_DATA;
    logic        ROM_WE;
    logic [3:0]  ROM_CS;
    logic [16:0] ROM_AD;
    logic [7:0]  ROM_DT;
    logic        CORE_RST_N;
    logic        LOAD_OK;
    logic [1:0]  LOAD_ERR;
    logic [15:0] CKSUM;

    rom_dl_router #(
        .R0_END(TB_R0),
        .R1_END(TB_R1),
        .R2_END(TB_R2),
        .R3_END(TB_R3),
        .HOLD  (TB_HOLD)
    ) dut (
        .MCLK      (MCLK),
        .RESET_N   (RESET_N),
        .DL_ACTIVE (DL_ACTIVE),
        .DL_WR     (DL_WR),
        .DL_ADDR   (DL_ADDR),
        .DL_DATA   (DL_DATA),
        .ROM_WE    (ROM_WE),
        .ROM_CS    (ROM_CS),
        .ROM_AD    (ROM_AD),
        .ROM_DT    (ROM_DT),
        .CORE_RST_N(CORE_RST_N),
        .LOAD_OK   (LOAD_OK),
        .LOAD_ERR  (LOAD_ERR),
        .CKSUM     (CKSUM)
    );

    typedef struct {
        logic [3:0]  cs;
        logic [16:0] ad;
        logic [7:0]  dt;
        int          cyc;
    } sb_t;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  dt;
        bit          we;
        logic [3:0]  cs;
        logic [16:0] ad;
    } vec_t;

    sb_t         sb_q[$];
    vec_t        vecs[10];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          rise;
    logic [15:0] exp_ck = 16'h0000;

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation timeout, got running, want finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Write-port monitor: every ROM_WE must match the oldest expectation, one cycle after drive
    always @(posedge MCLK) begin
        sb_t e;
        cyc = cyc + 1;
        #1;
        if (ROM_WE === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_extra_we: got ROM_WE=1 AD=0x%0h, want no write", ROM_AD);
            end else begin
                e = sb_q.pop_front();
                chk("wr_cs", ROM_CS, e.cs);
                chk("wr_ad", ROM_AD, e.ad);
                chk("wr_dt", ROM_DT, e.dt);
                chk("wr_cycle", cyc, e.cyc);
            end
        end else begin
            chk("cs_idle", ROM_CS, 4'b0000);
        end
    end

    function automatic logic [3:0] m_cs(input logic [24:0] a);
        if (a < TB_R0) return 4'b0001;
        if (a < TB_R1) return 4'b0010;
        if (a < TB_R2) return 4'b0100;
        return 4'b1000;
    endfunction

    function automatic logic [16:0] m_ad(input logic [24:0] a);
        logic [24:0] r;
        if (a < TB_R0) r = a;
        else if (a < TB_R1) r = a - TB_R0;
        else if (a < TB_R2) r = a - TB_R1;
        else r = a - TB_R2;
        return r[16:0];
    endfunction

    task automatic push_exp(input logic [3:0] cs, input logic [16:0] ad, input logic [7:0] d);
        sb_t e;
        e.cs   = cs;
        e.ad   = ad;
        e.dt   = d;
        e.cyc  = cyc + 1;
        sb_q.push_back(e);
        exp_ck = exp_ck + {8'h00, d};
    endtask

    task automatic drive_wr(input logic [24:0] a);
        DL_WR   = 1'b1;
        DL_ADDR = a;
        DL_DATA = a[7:0];
        if (a < TB_R3) push_exp(m_cs(a), m_ad(a), a[7:0]);
    endtask

    task automatic strobe(input logic [24:0] a, input int gap);
        drive_wr(a);
        @(negedge MCLK);
        DL_WR = 1'b0;
        repeat (gap) @(negedge MCLK);
    endtask

    task automatic start_load();
        DL_ACTIVE = 1'b1;
        exp_ck    = 16'h0000;
        @(negedge MCLK);
    endtask

    task automatic load_range(input int lo, input int hi, input int gap);
        for (int a = lo; a <= hi; a++) strobe(a[24:0], gap);
    endtask

    // Drop DL_ACTIVE (optionally with a final write) and report the edge index of the reset release
    task automatic finish_dl(input bit wr_last, input logic [24:0] a, output int r);
        DL_ACTIVE = 1'b0;
        if (wr_last) drive_wr(a);
        r = 0;
        for (int i = 1; i <= int'(TB_HOLD) + 8; i++) begin
            @(posedge MCLK);
            #2;
            if (i == 1) DL_WR = 1'b0;
            if (CORE_RST_N === 1'b1 && r == 0) r = i;
        end
        @(negedge MCLK);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_we"}, ROM_WE, 0);
        chk({tag, "_cs"}, ROM_CS, 0);
        chk({tag, "_ad"}, ROM_AD, 0);
        chk({tag, "_dt"}, ROM_DT, 0);
        chk({tag, "_rstn"}, CORE_RST_N, 0);
        chk({tag, "_ok"}, LOAD_OK, 0);
        chk({tag, "_err"}, LOAD_ERR, 0);
        chk({tag, "_ck"}, CKSUM, 0);
    endtask

    initial begin
        vecs[0] = '{addr: 25'h0000000, dt: 8'h11, we: 1'b1, cs: 4'b0001, ad: 17'h000};
        vecs[1] = '{addr: 25'h000017F, dt: 8'h22, we: 1'b1, cs: 4'b0001, ad: 17'h17F};
        vecs[2] = '{addr: 25'h0000180, dt: 8'h33, we: 1'b1, cs: 4'b0010, ad: 17'h000};
        vecs[3] = '{addr: 25'h00001FF, dt: 8'h44, we: 1'b1, cs: 4'b0010, ad: 17'h07F};
        vecs[4] = '{addr: 25'h0000200, dt: 8'h55, we: 1'b1, cs: 4'b0100, ad: 17'h000};
        vecs[5] = '{addr: 25'h00002FF, dt: 8'h66, we: 1'b1, cs: 4'b0100, ad: 17'h0FF};
        vecs[6] = '{addr: 25'h0000300, dt: 8'h77, we: 1'b1, cs: 4'b1000, ad: 17'h000};
        vecs[7] = '{addr: 25'h00003FF, dt: 8'h88, we: 1'b1, cs: 4'b1000, ad: 17'h0FF};
        vecs[8] = '{addr: 25'h0000400, dt: 8'h99, we: 1'b0, cs: 4'b0000, ad: 17'h000};
        vecs[9] = '{addr: 25'h1FFFFFF, dt: 8'hAA, we: 1'b0, cs: 4'b0000, ad: 17'h000};

        RESET_N   = 1'b0;
        DL_ACTIVE = 1'b0;
        DL_WR     = 1'b0;
        DL_ADDR   = '0;
        DL_DATA   = '0;
        repeat (3) @(negedge MCLK);
        chk_reset("por");
        RESET_N = 1'b1;

        // Strobe while idle must not reach the ROM port
        DL_WR   = 1'b1;
        DL_ADDR = 25'h10;
        @(negedge MCLK);
        DL_WR = 1'b0;
        @(negedge MCLK);
        chk("idle_rstn", CORE_RST_N, 0);

        // Boundary decode table, including two out-of-range writes
        start_load();
        foreach (vecs[i]) begin
            DL_WR   = 1'b1;
            DL_ADDR = vecs[i].addr;
            DL_DATA = vecs[i].dt;
            if (vecs[i].we) push_exp(vecs[i].cs, vecs[i].ad, vecs[i].dt);
            @(negedge MCLK);
            DL_WR = 1'b0;
            @(negedge MCLK);
        end
        finish_dl(1'b0, '0, rise);
        chk("tbl_rise", rise, 0);
        chk("tbl_err", LOAD_ERR, 2'b11);
        chk("tbl_ok", LOAD_OK, 0);

        // Full load, one strobe every 4 cycles
        start_load();
        load_range(0, int'(TB_R3) - 1, 3);
        finish_dl(1'b0, '0, rise);
        chk("full_rise", rise, TB_HOLD + 2);
        chk("full_ok", LOAD_OK, 1);
        chk("full_err", LOAD_ERR, 0);
        chk("full_rstn", CORE_RST_N, 1);
        chk("full_ck", CKSUM, CkEn ? exp_ck : 16'h0000);

        // Re-download from RUN, then back-to-back strobes across the region 0/1 boundary
        DL_ACTIVE = 1'b1;
        exp_ck    = 16'h0000;
        @(posedge MCLK);
        #2;
        chk("redl_rstn", CORE_RST_N, 0);
        chk("redl_ok", LOAD_OK, 0);
        @(negedge MCLK);
        strobe(25'h0, 0);
        for (int i = 0; i < 8; i++) strobe(TB_R0 - 25'd4 + 25'(i), 0);
        finish_dl(1'b0, '0, rise);
        chk("b2b_rise", rise, 0);
        chk("b2b_err", LOAD_ERR, 2'b10);
        chk("b2b_ck", CKSUM, CkEn ? exp_ck : 16'h0000);

        // Full load plus one write past the end
        start_load();
        load_range(0, int'(TB_R3) - 1, 0);
        strobe(TB_R3, 0);
        finish_dl(1'b0, '0, rise);
        chk("oor_rise", rise, 0);
        chk("oor_err", LOAD_ERR, 2'b01);
        chk("oor_ok", LOAD_OK, 0);
        chk("oor_rstn", CORE_RST_N, 0);

        // Short load, last write coincident with DL_ACTIVE falling
        start_load();
        load_range(0, int'(TB_R3) - 3, 0);
        finish_dl(1'b1, TB_R3 - 25'd2, rise);
        chk("short_rise", rise, 0);
        chk("short_err", LOAD_ERR, 2'b10);
        chk("short_ok", LOAD_OK, 0);
        chk("short_rstn", CORE_RST_N, 0);

        // Full reload, final byte written in the same cycle DL_ACTIVE falls
        start_load();
        load_range(0, int'(TB_R3) - 2, 0);
        finish_dl(1'b1, TB_R3 - 25'd1, rise);
        chk("reload_rise", rise, TB_HOLD + 2);
        chk("reload_ok", LOAD_OK, 1);
        chk("reload_err", LOAD_ERR, 0);
        chk("reload_ck", CKSUM, CkEn ? exp_ck : 16'h0000);

        // Reset for two cycles mid-load with DL_ACTIVE held high
        start_load();
        load_range(0, 'h0FF, 0);
        RESET_N = 1'b0;
        @(negedge MCLK);
        chk_reset("mid");
        @(negedge MCLK);
        RESET_N = 1'b1;
        @(negedge MCLK);
        exp_ck = 16'h0000;
        load_range('h100, int'(TB_R3) - 1, 0);
        finish_dl(1'b0, '0, rise);
        chk("mid_rise", rise, 0);
        chk("mid_err1", LOAD_ERR[1], 1);
        chk("mid_err", LOAD_ERR, 2'b10);
        chk("mid_ck", CKSUM, CkEn ? exp_ck : 16'h0000);

        repeat (2) @(negedge MCLK);
        chk("sb_drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
